// File: rtl/acc_drain.sv
// Snapshots a row of NUM_PE signed accumulators, saturates each one and streams them out over valid/ready.
// Optional build macro ACC_DRAIN_RELU_EN applies a ReLU after saturation.
module acc_drain #(
  parameter int NUM_PE    = 4,
  parameter int ACC_WIDTH = 17,
  parameter int OUT_WIDTH = 9,
  parameter int IDX_WIDTH = $clog2(NUM_PE)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          capture_i,
  input  logic [NUM_PE*ACC_WIDTH-1:0]   acc_i,
  output logic                          busy_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [OUT_WIDTH-1:0]          data_o,
  output logic [IDX_WIDTH-1:0]          idx_o,
  output logic                          last_o,
  output logic                          done_o,
  output logic                          drop_o,
  output logic [0:0]                    state_dbg
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PE - 1);

  // Clamp bounds expressed at accumulator width so the compare is a plain signed compare.
  localparam logic [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Handshake: an element moves on a rising clk edge where valid_o && ready_i;
  // once valid_o is high it stays high, with data_o/idx_o/last_o frozen, until that transfer.

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] index;
  logic [OUT_WIDTH-1:0] shadow [NUM_PE];

  logic xfer;
  logic final_xfer;
  logic load;

  function automatic logic [OUT_WIDTH-1:0] conv(input logic [ACC_WIDTH-1:0] v);
    logic [OUT_WIDTH-1:0] s;
    if ($signed(v) > $signed(SAT_HI)) begin
      s = SAT_HI[OUT_WIDTH-1:0];
    end else if ($signed(v) < $signed(SAT_LO)) begin
      s = SAT_LO[OUT_WIDTH-1:0];
    end else begin
      s = v[OUT_WIDTH-1:0];
    end
`ifdef ACC_DRAIN_RELU_EN
    if (s[OUT_WIDTH-1]) begin
      s = '0;
    end
`endif
    return s;
  endfunction

  assign xfer       = valid_o && ready_i;
  assign final_xfer = xfer && (index == LAST_IDX);
  // A capture is accepted when idle or exactly on the closing transfer of a burst.
  assign load       = capture_i && ((state == IDLE) || final_xfer);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      index  <= '0;
      done_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      drop_o <= 1'b0;
      case (state)
        IDLE: begin
          if (capture_i) begin
            state <= SEND;
            index <= '0;
          end
        end
        SEND: begin
          if (final_xfer) begin
            done_o <= 1'b1;
            index  <= '0;
            if (!capture_i) begin
              state <= IDLE;
            end
          end else if (xfer) begin
            index <= index + 1'b1;
          end
          if (capture_i && !final_xfer) begin
            drop_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

  // Values are saturated on the way in so the output path is a pure register mux.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_PE; k++) begin
        shadow[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < NUM_PE; k++) begin
        shadow[k] <= conv(acc_i[k*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
  end

  assign valid_o   = (state == SEND);
  assign busy_o    = (state == SEND);
  assign data_o    = shadow[index];
  assign idx_o     = index;
  assign last_o    = (state == SEND) && (index == LAST_IDX);
  assign state_dbg = state;

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: directed and randomized bursts checked against a queue of expected
// clamped values computed with plain integer arithmetic.
module tb_acc_drain;
  localparam int NUM_PE    = 4;
  localparam int ACC_WIDTH = 17;
  localparam int OUT_WIDTH = 9;
  localparam int IDX_WIDTH = $clog2(NUM_PE);

  logic                        clk;
  logic                        rstn;
  logic                        capture_i;
  logic [NUM_PE*ACC_WIDTH-1:0] acc_i;
  logic                        busy_o;
  logic                        valid_o;
  logic                        ready_i;
  logic [OUT_WIDTH-1:0]        data_o;
  logic [IDX_WIDTH-1:0]        idx_o;
  logic                        last_o;
  logic                        done_o;
  logic                        drop_o;
  logic [0:0]                  state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cur_acc[NUM_PE];
  bit done_exp = 0;
  bit drop_exp = 0;

  acc_drain #(
    .NUM_PE(NUM_PE), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk(clk), .rstn(rstn), .capture_i(capture_i), .acc_i(acc_i), .busy_o(busy_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .idx_o(idx_o), .last_o(last_o),
    .done_o(done_o), .drop_o(drop_o), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference model: clamp to signed OUT_WIDTH range, optional ReLU
  function automatic int ref_val(input int v);
    int lim;
    int r;
    lim = 1 << (OUT_WIDTH - 1);
    r = v;
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
`ifdef ACC_DRAIN_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic int rand_acc();
    if ($urandom_range(0, 1) == 0)
      return int'($urandom_range(0, 600)) - 300;
    return int'($urandom_range(0, (1 << ACC_WIDTH) - 1)) - (1 << (ACC_WIDTH - 1));
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_acc();
    for (int k = 0; k < NUM_PE; k++) acc_i[k*ACC_WIDTH +: ACC_WIDTH] = cur_acc[k][ACC_WIDTH-1:0];
  endtask

  task automatic scramble_acc();
    for (int k = 0; k < NUM_PE; k++) acc_i[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'($urandom);
  endtask

  task automatic rand_load();
    for (int k = 0; k < NUM_PE; k++) cur_acc[k] = rand_acc();
  endtask

  // driver: capture cur_acc from idle
  task automatic capture_burst();
    drive_acc();
    chk("idle_valid", int'(valid_o), 0);
    chk("idle_busy", int'(busy_o), 0);
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    for (int k = 0; k < NUM_PE; k++) exp_q.push_back(ref_val(cur_acc[k]));
  endtask

  // driver + scoreboard: stream one burst; mask gives ready per cycle,
  // mid_cap is the element index at which a (to-be-dropped) capture is issued,
  // chain issues a fresh capture on the final transfer.
  task automatic drain(input logic [31:0] mask, input int mid_cap, input bit chain);
    int k = 0;
    int cyc = 0;
    bit r;
    bit fin;
    bit mid_done = 0;
    bit cap_mid;
    while (k < NUM_PE && cyc < 64) begin
      chk("valid", int'(valid_o), 1);
      chk("busy", int'(busy_o), 1);
      chk("idx", int'(idx_o), k);
      chk("last", int'(last_o), (k == NUM_PE - 1) ? 1 : 0);
      chk("data", int'($signed(data_o)), exp_q[0]);
      chk("done", int'(done_o), int'(done_exp));
      chk("drop", int'(drop_o), int'(drop_exp));
      r = mask[cyc % 32];
      fin = (k == NUM_PE - 1);
      cap_mid = 0;
      if (chain && fin) r = 1'b1;
      ready_i = r;
      if (chain && fin) begin
        rand_load();
        drive_acc();
        capture_i = 1'b1;
        for (int j = 0; j < NUM_PE; j++) exp_q.push_back(ref_val(cur_acc[j]));
      end else if (k == mid_cap && !mid_done) begin
        mid_done = 1;
        cap_mid = 1;
        capture_i = 1'b1;
        scramble_acc();
      end else if (!r) begin
        scramble_acc();
      end
      tick();
      capture_i = 1'b0;
      drop_exp = cap_mid;
      done_exp = r && fin;
      if (r) begin
        void'(exp_q.pop_front());
        k++;
      end
      cyc++;
    end
    if (k < NUM_PE) chk("drain_timeout", k, NUM_PE);
    if (!chain) begin
      chk("end_valid", int'(valid_o), 0);
      chk("end_busy", int'(busy_o), 0);
      chk("end_done", int'(done_o), int'(done_exp));
      chk("end_drop", int'(drop_o), int'(drop_exp));
      ready_i = 1'b0;
      tick();
      chk("done_pulse_end", int'(done_o), 0);
      done_exp = 0;
      drop_exp = 0;
    end
  endtask

  initial begin
    rstn = 1'b0;
    capture_i = 1'b0;
    ready_i = 1'b0;
    acc_i = '0;
    #12;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_idx", int'(idx_o), 0);
    chk("rst_last", int'(last_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_drop", int'(drop_o), 0);
    tick();
    rstn = 1'b1;
    tick();

    // basic burst: PE0..PE3 = 7, 0, -3, 40
    cur_acc = '{7, 0, -3, 40};
    capture_burst();
    drain(32'hFFFF_FFFF, -1, 0);

    // saturation corners
    cur_acc = '{300, -1000, 255, -256};
    capture_burst();
`ifdef ACC_DRAIN_RELU_EN
    chk("sat_model0", exp_q[1], 0);
`else
    chk("sat_model0", exp_q[1], -256);
`endif
    drain(32'hFFFF_FFFF, -1, 0);

    // backpressure: element 1 stalled for 3 cycles while acc_i changes
    rand_load();
    capture_burst();
    drain(32'hFFFF_FFF1, -1, 0);

    // capture mid-burst at idx 1 is dropped
    rand_load();
    capture_burst();
    drain(32'hFFFF_FFFF, 1, 0);

    // capture coincident with final transfer: back-to-back bursts
    rand_load();
    capture_burst();
    drain(32'hFFFF_FFFF, -1, 1);
    drain(32'hFFFF_FFFF, -1, 0);

    // reset mid-burst at idx 2 with ready low
    rand_load();
    capture_burst();
    ready_i = 1'b1;
    tick();
    tick();
    ready_i = 1'b0;
    chk("pre_rst_idx", int'(idx_o), 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_done", int'(done_o), 0);
    chk("arst_drop", int'(drop_o), 0);
    chk("arst_idx", int'(idx_o), 0);
    exp_q.delete();
    done_exp = 0;
    drop_exp = 0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_valid", int'(valid_o), 0);
      chk("post_rst_done", int'(done_o), 0);
    end
    rand_load();
    capture_burst();
    drain(32'hFFFF_FFFF, -1, 0);

    // randomized bursts
    for (int n = 0; n < 12; n++) begin
      int mc;
      bit ch;
      mc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_PE - 2)) : -1;
      ch = ($urandom_range(0, 2) == 0);
      rand_load();
      capture_burst();
      drain($urandom | 32'h1111_1111, mc, ch);
      if (ch) drain($urandom | 32'h1111_1111, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
